breakout_game_ctrl: RTL and testbench

//  Game-sequencing FSM for the breakout playfield. Refills the brick wall by holding the restore

---
 rtl/breakout_pkg.sv | 33 +++
 rtl/breakout_frame_timer.sv | 32 +++
 rtl/breakout_game_ctrl.sv | 154 +++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout game controller.
// Holds the state encoding, datapath widths, full-wall brick count and a saturating add.
package breakout_pkg;

    localparam int unsigned BRICK_COLS  = 19;
    localparam int unsigned BRICK_ROWS  = 7;
    localparam int unsigned BRICKS_FULL = BRICK_COLS * BRICK_ROWS;

    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned LIVES_W  = 3;
    localparam int unsigned LEVEL_W  = 4;
    localparam int unsigned BRICKS_W = 8;
    localparam int unsigned FRAME_W  = 8;
    localparam int unsigned POINTS_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRestore,
        StServe,
        StPlay,
        StLost,
        StOver
    } state_e;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0]  a,
                                                   input logic [POINTS_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W + 1)'(b);
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/breakout_frame_timer.sv
// Frame counter for the serve hold: counts frame_start ticks while enabled, clears on request.
// o_expire flags the tick that brings the count up to TERMINAL.
module breakout_frame_timer
    import breakout_pkg::*;
#(
    parameter int unsigned TERMINAL = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_tick,
    output logic o_expire
);

    logic [FRAME_W-1:0] r_count;
    logic [FRAME_W:0]   w_next;

    assign w_next   = {1'b0, r_count} + (FRAME_W + 1)'(1);
    assign o_expire = i_enable & i_tick & (w_next >= (FRAME_W + 1)'(TERMINAL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && i_tick && (r_count != {FRAME_W{1'b1}})) begin
            r_count <= w_next[FRAME_W-1:0];
        end
    end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: wall restore, serve/run gating, score, bricks, lives and level.
// Every output is a register updated one cycle after the event that causes it.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int unsigned BRICK_COUNT  = BRICKS_FULL,
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINTS       = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_frame_start,
    input  logic                i_start_btn,
    input  logic                i_ball_lost,
    input  logic                i_brick_hit_acq,
    output logic                o_restore_brick_wall,
    output logic                o_ball_serve,
    output logic                o_ball_run,
    output logic [SCORE_W-1:0]  o_score,
    output logic [LIVES_W-1:0]  o_lives,
    output logic [LEVEL_W-1:0]  o_level,
    output logic [BRICKS_W-1:0] o_bricks_left,
    output logic                o_game_over
);

    localparam logic [LIVES_W-1:0]  LIVES_INIT  = LIVES_W'(START_LIVES);
    localparam logic [BRICKS_W-1:0] BRICKS_INIT = BRICKS_W'(BRICK_COUNT);
    localparam logic [POINTS_W-1:0] POINTS_V    = POINTS_W'(POINTS);

    state_e              r_state;
    logic                r_start_prev;
    logic                r_restore;
    logic                r_serve;
    logic                r_run;
    logic                r_over;
    logic [SCORE_W-1:0]  r_score;
    logic [LIVES_W-1:0]  r_lives;
    logic [LEVEL_W-1:0]  r_level;
    logic [BRICKS_W-1:0] r_bricks;

    logic w_start_edge;
    logic w_last_brick;
    logic w_timer_clr;
    logic w_timer_en;
    logic w_serve_done;

    assign w_start_edge = i_start_btn & ~r_start_prev;
    assign w_last_brick = i_brick_hit_acq & (r_bricks == BRICKS_W'(1));
    assign w_timer_clr  = ((r_state == StRestore) & i_frame_start) | (r_state == StLost);
    assign w_timer_en   = (r_state == StServe);

    breakout_frame_timer #(
        .TERMINAL (SERVE_FRAMES)
    ) u_frame_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_timer_clr),
        .i_enable (w_timer_en),
        .i_tick   (i_frame_start),
        .o_expire (w_serve_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_start_prev <= 1'b0;
            r_restore    <= 1'b0;
            r_serve      <= 1'b0;
            r_run        <= 1'b0;
            r_over       <= 1'b0;
            r_score      <= '0;
            r_lives      <= LIVES_INIT;
            r_level      <= '0;
            r_bricks     <= '0;
        end else begin
            r_start_prev <= i_start_btn;
            case (r_state)
                StIdle, StOver: begin
                    if (w_start_edge) begin
                        r_state <= StArm;
                        r_over  <= 1'b0;
                        r_score <= '0;
                        r_lives <= LIVES_INIT;
                        r_level <= '0;
                    end
                end
                StArm: begin
                    if (i_frame_start) begin
                        r_state   <= StRestore;
                        r_restore <= 1'b1;
                    end
                end
                StRestore: begin
                    if (i_frame_start) begin
                        r_state   <= StServe;
                        r_restore <= 1'b0;
                        r_serve   <= 1'b1;
                        r_bricks  <= BRICKS_INIT;
                    end
                end
                StServe: begin
                    if (w_start_edge || w_serve_done) begin
                        r_state <= StPlay;
                        r_serve <= 1'b0;
                        r_run   <= 1'b1;
                    end
                end
                StPlay: begin
                    if (i_brick_hit_acq) begin
                        r_score <= sat_add(r_score, POINTS_V);
                        if (r_bricks != '0) begin
                            r_bricks <= r_bricks - BRICKS_W'(1);
                        end
                    end
                    // Clearing the wall outranks a coincident ball loss.
                    if (w_last_brick) begin
                        r_state <= StArm;
                        r_run   <= 1'b0;
                        r_level <= r_level + LEVEL_W'(1);
                    end else if (i_ball_lost) begin
                        r_state <= StLost;
                        r_run   <= 1'b0;
                    end
                end
                StLost: begin
                    if (r_lives != '0) begin
                        r_lives <= r_lives - LIVES_W'(1);
                    end
                    if (r_lives <= LIVES_W'(1)) begin
                        r_state <= StOver;
                        r_over  <= 1'b1;
                    end else begin
                        r_state <= StServe;
                        r_serve <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_restore_brick_wall = r_restore;
    assign o_ball_serve         = r_serve;
    assign o_ball_run           = r_run;
    assign o_score              = r_score;
    assign o_lives              = r_lives;
    assign o_level              = r_level;
    assign o_bricks_left        = r_bricks;
    assign o_game_over          = r_over;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Self-checking bench for breakout_game_ctrl: a default instance for game flow and a
// POINTS=15 instance that drives the score into saturation across many levels.
module tb_breakout_game_ctrl;

    typedef struct packed {
        logic        restore;
        logic        serve;
        logic        run;
        logic [15:0] score;
        logic [2:0]  lives;
        logic [3:0]  level;
        logic [7:0]  bricks;
        logic        over;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fs = 1'b0;
    logic btn = 1'b0;
    logic lost = 1'b0;
    logic ack = 1'b0;

    logic        d_restore, d_serve, d_run, d_over;
    logic [15:0] d_score;
    logic [2:0]  d_lives;
    logic [3:0]  d_level;
    logic [7:0]  d_bricks;

    logic        s_restore, s_serve, s_run, s_over;
    logic [15:0] s_score;
    logic [2:0]  s_lives;
    logic [3:0]  s_level;
    logic [7:0]  s_bricks;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    breakout_game_ctrl u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_frame_start        (fs),
        .i_start_btn          (btn),
        .i_ball_lost          (lost),
        .i_brick_hit_acq      (ack),
        .o_restore_brick_wall (d_restore),
        .o_ball_serve         (d_serve),
        .o_ball_run           (d_run),
        .o_score              (d_score),
        .o_lives              (d_lives),
        .o_level              (d_level),
        .o_bricks_left        (d_bricks),
        .o_game_over          (d_over)
    );

    breakout_game_ctrl #(
        .BRICK_COUNT  (255),
        .START_LIVES  (1),
        .SERVE_FRAMES (1),
        .POINTS       (15)
    ) u_sat (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_frame_start        (fs),
        .i_start_btn          (btn),
        .i_ball_lost          (lost),
        .i_brick_hit_acq      (ack),
        .o_restore_brick_wall (s_restore),
        .o_ball_serve         (s_serve),
        .o_ball_run           (s_run),
        .o_score              (s_score),
        .o_lives              (s_lives),
        .o_level              (s_level),
        .o_bricks_left        (s_bricks),
        .o_game_over          (s_over)
    );

    function automatic obs_t obs_main();
        obs_t o;
        o = {d_restore, d_serve, d_run, d_score, d_lives, d_level, d_bricks, d_over};
        return o;
    endfunction

    function automatic obs_t obs_sat();
        obs_t o;
        o = {s_restore, s_serve, s_run, s_score, s_lives, s_level, s_bricks, s_over};
        return o;
    endfunction

    function automatic obs_t mk(input logic r, input logic s, input logic run, input int sc,
                                input int lv, input int lvl, input int br, input logic ov);
        obs_t o;
        o.restore = r;
        o.serve   = s;
        o.run     = run;
        o.score   = sc[15:0];
        o.lives   = lv[2:0];
        o.level   = lvl[3:0];
        o.bricks  = br[7:0];
        o.over    = ov;
        return o;
    endfunction

    // One-cycle stimulus pulse; returns on the negedge where the response is visible.
    task automatic pulse(input logic f, input logic b, input logic l, input logic a);
        @(negedge clk);
        fs = f; btn = b; lost = l; ack = a;
        @(negedge clk);
        fs = 1'b0; btn = 1'b0; lost = 1'b0; ack = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, a;
        string n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0)); name_q.push_back("reset_state");
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0)); name_q.push_back("reset_state_sat");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_sat(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_restore();
        obs_t e, a;
        string n;
        int cnt;
        localparam int G = 20;
        pulse(0, 1, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0)); name_q.push_back("arm_after_start");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(1, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0)); name_q.push_back("restore_high");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        cnt = 0;
        for (int i = 0; i < G; i++) begin
            ack = (i == 3);
            if (d_restore) cnt++;
            @(negedge clk);
        end
        ack = 1'b0;
        fs = 1'b1;
        if (d_restore) cnt++;
        @(negedge clk);
        fs = 1'b0;
        n_checks++;
        if (cnt !== G + 1) begin
            n_errors++;
            $display("FAIL restore_one_frame: actual %0d cycles required %0d", cnt, G + 1);
        end
        exp_q.push_back(mk(0, 1, 0, 0, 3, 0, 133, 0)); name_q.push_back("serve_after_restore");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
    endtask

    task automatic test_serve_to_play();
        obs_t e, a;
        string n;
        for (int i = 0; i < 59; i++) pulse(1, 0, (i == 10), 0);
        exp_q.push_back(mk(0, 1, 0, 0, 3, 0, 133, 0)); name_q.push_back("serve_hold_59");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(1, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 1, 0, 3, 0, 133, 0)); name_q.push_back("play_after_60");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
    endtask

    task automatic test_acks();
        obs_t e, a;
        string n;
        for (int i = 1; i <= 5; i++) begin
            pulse(0, 0, 0, 1);
            exp_q.push_back(mk(0, 0, 1, i, 3, 0, 133 - i, 0));
            name_q.push_back($sformatf("ack_%0d", i));
            e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
            if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        end
    endtask

    task automatic test_lives();
        obs_t e, a;
        string n;
        // First loss arrives with an ack that is not the last brick.
        pulse(0, 0, 1, 1);
        exp_q.push_back(mk(0, 0, 0, 6, 3, 0, 127, 0)); name_q.push_back("lost_with_ack");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        @(negedge clk);
        exp_q.push_back(mk(0, 1, 0, 6, 2, 0, 127, 0)); name_q.push_back("serve_after_loss1");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(0, 1, 0, 0);
        exp_q.push_back(mk(0, 0, 1, 6, 2, 0, 127, 0)); name_q.push_back("start_skips_serve");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(0, 0, 1, 0);
        @(negedge clk);
        exp_q.push_back(mk(0, 1, 0, 6, 1, 0, 127, 0)); name_q.push_back("serve_after_loss2");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(1, 1, 0, 0);
        exp_q.push_back(mk(0, 0, 1, 6, 1, 0, 127, 0)); name_q.push_back("frame_and_start");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(0, 0, 1, 0);
        exp_q.push_back(mk(0, 0, 0, 6, 1, 0, 127, 0)); name_q.push_back("lost_state_3");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        @(negedge clk);
        exp_q.push_back(mk(0, 0, 0, 6, 0, 0, 127, 1)); name_q.push_back("game_over");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 1);
        exp_q.push_back(mk(0, 0, 0, 6, 0, 0, 127, 1)); name_q.push_back("over_ignores_input");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
    endtask

    task automatic test_level_clear();
        obs_t e, a;
        string n;
        pulse(0, 1, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 3, 0, 127, 0)); name_q.push_back("over_restart");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        for (int i = 0; i < 132; i++) pulse(0, 0, 0, 1);
        exp_q.push_back(mk(0, 0, 1, 132, 3, 0, 1, 0)); name_q.push_back("one_brick_left");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(0, 0, 1, 1);
        exp_q.push_back(mk(0, 0, 0, 133, 3, 1, 0, 0)); name_q.push_back("last_brick_beats_loss");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        @(negedge clk);
        exp_q.push_back(mk(0, 0, 0, 133, 3, 1, 0, 0)); name_q.push_back("no_life_lost");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        pulse(1, 0, 0, 0);
        exp_q.push_back(mk(1, 0, 0, 133, 3, 1, 0, 0)); name_q.push_back("restore_level2");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
    endtask

    task automatic test_reset_mid_restore();
        obs_t e, a;
        string n;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0)); name_q.push_back("async_reset_restore");
        e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_main(); n_checks++;
        if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        obs_t e, a;
        string n;
        int k, sc, lvl, b;
        k = 0; sc = 0; lvl = 0;
        pulse(0, 1, 0, 0);
        while (k < 4370) begin
            pulse(1, 0, 0, 0);
            pulse(1, 0, 0, 0);
            pulse(1, 0, 0, 0);
            exp_q.push_back(mk(0, 0, 1, sc, 1, lvl, 255, 0));
            name_q.push_back($sformatf("sat_play_level_%0d", lvl));
            e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_sat(); n_checks++;
            if (a !== e) begin n_errors++; $display("FAIL %s: actual %h required %h", n, a, e); end
            b = 0;
            while (b < 255 && k < 4370) begin
                pulse(0, 0, 0, 1);
                k++; b++;
                sc = (sc + 15 > 65535) ? 65535 : sc + 15;
                if (b == 255) begin
                    lvl = (lvl + 1) % 16;
                    exp_q.push_back(mk(0, 0, 0, sc, 1, lvl, 0, 0));
                    name_q.push_back($sformatf("sat_level_clear_%0d", k));
                    e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_sat(); n_checks++;
                    if (a !== e) begin
                        n_errors++; $display("FAIL %s: actual %h required %h", n, a, e);
                    end
                end else if (k >= 4368) begin
                    exp_q.push_back(mk(0, 0, 1, sc, 1, lvl, 255 - b, 0));
                    name_q.push_back($sformatf("sat_score_ack_%0d", k));
                    e = exp_q.pop_front(); n = name_q.pop_front(); a = obs_sat(); n_checks++;
                    if (a !== e) begin
                        n_errors++; $display("FAIL %s: actual %h required %h", n, a, e);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_restore();
        test_serve_to_play();
        test_acks();
        test_lives();
        test_level_clear();
        test_reset_mid_restore();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
